aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES encryption sequencer.
- Owns the 128-bit state register and round counter, and presents state and round key to an external round datapath each cycle.
- The round datapath is the combinational full round (SubBytes/ShiftRows/MixColumns/AddRoundKey) plus the last round (no MixColumns).
- Accepts plaintext blocks on a valid/ready handshake, returns ciphertext on a second valid/ready handshake, and holds the result until it is consumed.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8).
- NR, 10, number of rounds; must equal NK+6 (10/12/14). Elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  controller can accept a block.
- in_block  input  128  plaintext; bit 127 = byte 0.
- w  input  (NR+1)*128  expanded key, declared [0:(NR+1)*128-1]; round key r = w[r*128 +: 128].
- dp_state  output  128  state presented to the datapath; equals the internal state register.
- dp_key  output  128  round key for the current round.
- dp_round_out  input  128  full-round result for (dp_state, dp_key).
- dp_last_out  input  128  last-round result for (dp_state, dp_key).
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_block  output  128  ciphertext; equals the state register.
- busy  output  1  high in ROUND or LAST.
- round_idx  output  4  current round counter (0..NR).

Behaviour:
- Reset (async, active-high) values: state=IDLE, state register=0, round_idx=0, in_ready=1, out_valid=0, busy=0, dp_key=w[0 +: 128].
- FSM states: IDLE, ROUND, LAST, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: st <= in_block ^ w[0 +: 128]; round_idx <= 1; go to ROUND (or to LAST if NR==1, which is not legal).
- ROUND:
  - dp_key = w[round_idx*128 +: 128].
  - Each edge: st <= dp_round_out; round_idx++.
  - When round_idx==NR-1 at the edge, go to LAST (round_idx becomes NR).
- LAST:
  - dp_key = w[NR*128 +: 128].
  - At the edge: st <= dp_last_out; go to DONE.
- DONE:
  - out_valid=1; out_block stable.
  - On out_ready at an edge, go to IDLE and set round_idx <= 0.
  - in_ready=0 while in DONE: no overlap or bypass.
- Latency: out_valid rises NR edges after the accepting edge (10 for AES-128).
- Minimum issue interval is NR+2 cycles with out_ready held high.
- in_block and w are sampled only at the accept edge. w must stay stable from accept until out_valid; the controller does not latch w.
- in_valid while busy is ignored; no internal queue.
- out_ready while not in DONE is ignored.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - The partial state is discarded and out_valid never pulses for that block.
- dp_state/dp_key are driven in every state. Their value outside ROUND/LAST is don't-care for the datapath but must be deterministic (no X after reset).
- round_idx width is fixed at 4 bits and covers NR up to 14.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- When defined:
  - Extra input abort (1 bit).
  - abort=1 at an edge in ROUND or LAST returns the FSM to IDLE with round_idx=0. out_valid is never raised for that block.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the state update in the same cycle.
- When undefined: no abort port, and the FSM behaves exactly as above.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: NR=10, w expanded from key 000102030405060708090a0b0c0d0e0f, in_block 00112233445566778899aabbccddeeff, out_ready=1.
  - Required: out_block=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid rising exactly 10 edges after accept.
- Back-to-back blocks:
  - Stimulus: in_valid held high with two blocks, out_ready=1.
  - Required: second accept occurs 12 cycles after the first; both ciphertexts are correct; in_ready=0 throughout ROUND/LAST/DONE.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid.
  - Required: out_block held constant, in_ready=0, and the next accept occurs only after the out_ready handshake.
- Reset mid-operation:
  - Stimulus: assert reset at round_idx=5.
  - Required: out_valid=0, in_ready=1, round_idx=0, and a subsequent block encrypts correctly.
- AES-256 run:
  - Stimulus: NK=8, NR=14, FIPS-197 C.3 key 000102…1e1f with the same plaintext.
  - Required: out_block=8ea2b7ca516745bfeafc49904b496089 after 14 edges.
- Abort (only with AES_CTRL_ABORT_EN):
  - Stimulus: abort at round_idx=3.
  - Required: FSM returns to IDLE next cycle, no out_valid pulse, and the next block produces correct ciphertext.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: plaintext-in / ciphertext-out valid/ready bus for the
// iterative AES sequencer. The master is the block producer/consumer, the
// slave is the controller.
interface aes_round_ctrl_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_block;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_block;

  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer.
// Owns the 128-bit state register and round counter and presents state and
// round key to an external combinational round datapath every cycle.
// Build option: define AES_CTRL_ABORT_EN to add an 'abort' input that cancels
// a block that is still in ROUND or LAST.
module aes_round_ctrl #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef AES_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  aes_round_ctrl_if.slave       bus,
  input  logic [0:(NR+1)*128-1] w,
  output logic [127:0]          dp_state,
  output logic [127:0]          dp_key,
  input  logic [127:0]          dp_round_out,
  input  logic [127:0]          dp_last_out,
  output logic                  busy,
  output logic [3:0]            round_idx
);
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned RIDX_W = 4;
  localparam int unsigned W_W    = (NR + 1) * BLK_W;
  localparam int unsigned WIDX_W = $clog2(W_W);
  localparam logic [RIDX_W-1:0] NR_L  = RIDX_W'(NR);
  localparam logic [RIDX_W-1:0] NR_M1 = RIDX_W'(NR - 1);

  // Only the three AES key sizes are meaningful, and the round count is tied to them.
  if (NR != NK + 6) begin : g_bad_nr
    $error("aes_round_ctrl: NR=%0d must equal NK+6=%0d", NR, NK + 6);
  end
  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_round_ctrl: NK=%0d must be 4, 6 or 8", NK);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_LAST,
    S_DONE
  } state_e;

  state_e             fsm;
  logic [BLK_W-1:0]   st;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               abort_hit;
  logic [RIDX_W-1:0]  key_sel;
  logic [WIDX_W-1:0]  key_base;

`ifdef AES_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Round-key select; clamped so an out-of-range counter can never index past w.
  always_comb begin
    key_sel  = (round_idx > NR_L) ? NR_L : round_idx;
    key_base = WIDX_W'(32'(key_sel) * BLK_W);
  end

  assign dp_key        = w[key_base +: BLK_W];
  assign dp_state      = st;
  assign bus.out_block = st;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // Sequencer: accept, NR-1 full rounds, one last round, hold until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm         <= S_IDLE;
      st          <= '0;
      round_idx   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            st         <= bus.in_block ^ w[0 +: BLK_W];
            round_idx  <= RIDX_W'(1);
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            fsm        <= (NR == 1) ? S_LAST : S_ROUND;
          end
        end
        S_ROUND: begin
          if (abort_hit) begin
            st         <= '0;
            round_idx  <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
            fsm        <= S_IDLE;
          end else begin
            st        <= dp_round_out;
            round_idx <= round_idx + RIDX_W'(1);
            if (round_idx == NR_M1) begin
              fsm <= S_LAST;
            end
          end
        end
        S_LAST: begin
          if (abort_hit) begin
            st         <= '0;
            round_idx  <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
            fsm        <= S_IDLE;
          end else begin
            st          <= dp_last_out;
            busy        <= 1'b0;
            out_valid_q <= 1'b1;
            fsm         <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            round_idx   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm         <= S_IDLE;
          end
        end
        default: begin
          round_idx   <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy        <= 1'b0;
          fsm         <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for the AES round sequencer with an
// AES-128 instance (a) and an AES-256 instance (b), each driving a behavioural
// round datapath. Expected ciphertexts are FIPS-197 published values.
module tb_aes_round_ctrl;
  localparam int unsigned NR_A = 10;
  localparam int unsigned NR_B = 14;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                           input bit mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [127:0] r = '0;
    for (int n = 0; n < 16; n++) a[n] = sbox(8'(s >> (8 * (15 - n))));
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        o[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        o[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        o[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        o[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end else begin
        for (int rr = 0; rr < 4; rr++) o[4*c+rr] = b[4*c+rr];
      end
    end
    for (int n = 0; n < 16; n++) r = (r << 8) | 128'(o[n] ^ 8'(k >> (8 * (15 - n))));
    return r;
  endfunction

  // Expanded key, word 0 at index 0; unused tail words are zero.
  function automatic logic [0:1919] key_exp(input logic [0:255] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc  = 8'h01;
    logic [0:1919] res = '0;
    int            nw  = 4 * (nk + 7);
    for (int i = 0; i < 60; i++) wd[i] = 32'h0;
    for (int i = 0; i < nk; i++) wd[i] = 32'(key >> (224 - 32 * i));
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) res = (res << 32) | 1920'(wd[i]);
    return res;
  endfunction

  // ---------------- DUTs ----------------
  aes_round_ctrl_if ifa ();
  aes_round_ctrl_if ifb ();

  logic [0:(NR_A+1)*128-1] wa;
  logic [0:(NR_B+1)*128-1] wb;
  logic [127:0] dps_a, dpk_a, dpr_a, dpl_a;
  logic [127:0] dps_b, dpk_b, dpr_b, dpl_b;
  logic         busy_a, busy_b;
  logic [3:0]   ridx_a, ridx_b;
`ifdef AES_CTRL_ABORT_EN
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
`endif

  aes_round_ctrl #(.NK(4), .NR(NR_A)) dut_a (
    .clk          (clk),
    .reset        (reset),
`ifdef AES_CTRL_ABORT_EN
    .abort        (abort_a),
`endif
    .bus          (ifa),
    .w            (wa),
    .dp_state     (dps_a),
    .dp_key       (dpk_a),
    .dp_round_out (dpr_a),
    .dp_last_out  (dpl_a),
    .busy         (busy_a),
    .round_idx    (ridx_a)
  );

  aes_round_ctrl #(.NK(8), .NR(NR_B)) dut_b (
    .clk          (clk),
    .reset        (reset),
`ifdef AES_CTRL_ABORT_EN
    .abort        (abort_b),
`endif
    .bus          (ifb),
    .w            (wb),
    .dp_state     (dps_b),
    .dp_key       (dpk_b),
    .dp_round_out (dpr_b),
    .dp_last_out  (dpl_b),
    .busy         (busy_b),
    .round_idx    (ridx_b)
  );

  always_comb begin
    dpr_a = aes_rnd(dps_a, dpk_a, 1'b1);
    dpl_a = aes_rnd(dps_a, dpk_a, 1'b0);
    dpr_b = aes_rnd(dps_b, dpk_b, 1'b1);
    dpl_b = aes_rnd(dps_b, dpk_b, 1'b0);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboards / monitors ----------------
  logic [127:0] exp_a [$];
  logic [127:0] exp_b [$];
  logic [127:0] nexp_a = '0;
  logic [127:0] nexp_b = '0;
  int  acc_a = 0, acc_b = 0;
  int  unexp_a = 0, unexp_b = 0;
  int  inv_a = 0, inv_b = 0;
  bit  ov_a_q = 1'b0, ov_b_q = 1'b0;

  always @(negedge clk) begin
    if (reset) ov_a_q = 1'b0;
    else begin
      if (ifa.in_valid && ifa.in_ready) begin
        exp_a.push_back(nexp_a);
        acc_a = cyc + 1;
      end
      if (ifa.out_valid && !ov_a_q) chk("latency_a", 128'(cyc - acc_a), 128'(NR_A));
      ov_a_q = ifa.out_valid;
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_a.size() == 0) unexp_a++;
        else chk("cipher_a", ifa.out_block, exp_a.pop_front());
      end
      if (ifa.in_ready && (busy_a || ifa.out_valid)) inv_a++;
    end
  end

  always @(negedge clk) begin
    if (reset) ov_b_q = 1'b0;
    else begin
      if (ifb.in_valid && ifb.in_ready) begin
        exp_b.push_back(nexp_b);
        acc_b = cyc + 1;
      end
      if (ifb.out_valid && !ov_b_q) chk("latency_b", 128'(cyc - acc_b), 128'(NR_B));
      ov_b_q = ifb.out_valid;
      if (ifb.out_valid && ifb.out_ready) begin
        if (exp_b.size() == 0) unexp_b++;
        else chk("cipher_b", ifb.out_block, exp_b.pop_front());
      end
      if (ifb.in_ready && (busy_b || ifb.out_valid)) inv_b++;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rdy(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction

  function automatic logic ovl(input bit sel);
    return sel ? ifb.out_valid : ifa.out_valid;
  endfunction

  task automatic issue(input bit sel, input logic [127:0] pt, input logic [127:0] ct,
                       input bit hold);
    int n = 0;
    if (sel) begin ifb.in_block = pt; nexp_b = ct; ifb.in_valid = 1'b1; end
    else begin ifa.in_block = pt; nexp_a = ct; ifa.in_valid = 1'b1; end
    do begin @(negedge clk); n++; end while (!rdy(sel) && n < 100);
    chk(sel ? "accept_b" : "accept_a", 128'(rdy(sel)), 128'(1));
    @(posedge clk); #1;
    if (!hold) begin
      if (sel) ifb.in_valid = 1'b0; else ifa.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input bit sel);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ovl(sel) && n < 100);
    chk(sel ? "out_seen_b" : "out_seen_a", 128'(ovl(sel)), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rdy(sel) && n < 100);
    chk(sel ? "idle_b" : "idle_a", 128'(rdy(sel)), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_ridx_a(input logic [3:0] r);
    int n = 0;
    do begin @(negedge clk); n++; end while (ridx_a != r && n < 50);
    chk("ridx_reached", 128'(ridx_a), 128'(r));
  endtask

  task automatic quiet_a(input string nm);
    int bad = 0;
    repeat (2 * NR_A) begin
      @(negedge clk);
      if (ifa.out_valid) bad++;
    end
    chk(nm, 128'(bad), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:1919] kx;
    int a1;
    int p;

    ifa.in_valid = 1'b0; ifa.in_block = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_block = '0; ifb.out_ready = 1'b1;
    kx = key_exp({K1, 128'h0}, 4); wa = kx[0 +: (NR_A+1)*128];
    kx = key_exp(K3, 8);           wb = kx[0 +: (NR_B+1)*128];

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_a",  128'(ifa.in_ready),  128'(1));
    chk("rst_out_valid_a", 128'(ifa.out_valid), 128'(0));
    chk("rst_busy_a",      128'(busy_a),        128'(0));
    chk("rst_ridx_a",      128'(ridx_a),        128'(0));
    chk("rst_state_a",     dps_a,               128'(0));
    chk("rst_key_a",       dpk_a,               K1);
    chk("rst_key_b",       dpk_b,               K1);
    @(posedge clk); #1;
    reset = 1'b0;

    // FIPS-197 C.1
    issue(1'b0, PT, CT1, 1'b0);
    wait_out(1'b0);
    wait_idle(1'b0);

    // Back-to-back with in_valid held
    issue(1'b0, PT, CT1, 1'b1);
    a1 = acc_a;
    issue(1'b0, PT, CT1, 1'b0);
    chk("b2b_gap", 128'(acc_a - a1), 128'(NR_A + 2));
    wait_out(1'b0);
    wait_idle(1'b0);

    // Backpressure, new key loaded while idle
    kx = key_exp({KB, 128'h0}, 4); wa = kx[0 +: (NR_A+1)*128];
    ifa.out_ready = 1'b0;
    issue(1'b0, PTB, CTB, 1'b0);
    wait_out(1'b0);
    ifa.in_block = PTB; nexp_a = CTB; ifa.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_block", ifa.out_block,        CTB);
      chk("bp_in_ready",  128'(ifa.in_ready),   128'(0));
      chk("bp_out_valid", 128'(ifa.out_valid),  128'(1));
    end
    @(posedge clk); #1;
    p = cyc;
    ifa.out_ready = 1'b1;
    issue(1'b0, PTB, CTB, 1'b0);
    chk("bp_accept_edge", 128'(acc_a), 128'(p + 2));
    wait_out(1'b0);
    wait_idle(1'b0);

    // Reset mid-operation
    kx = key_exp({K1, 128'h0}, 4); wa = kx[0 +: (NR_A+1)*128];
    issue(1'b0, PT, CT1, 1'b0);
    wait_ridx_a(4'd5);
    reset = 1'b1;
    if (exp_a.size() > 0) exp_a.delete(exp_a.size() - 1);
    #1;
    chk("mid_rst_out_valid", 128'(ifa.out_valid), 128'(0));
    chk("mid_rst_in_ready",  128'(ifa.in_ready),  128'(1));
    chk("mid_rst_ridx",      128'(ridx_a),        128'(0));
    chk("mid_rst_busy",      128'(busy_a),        128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    quiet_a("no_out_after_reset");
    issue(1'b0, PT, CT1, 1'b0);
    wait_out(1'b0);
    wait_idle(1'b0);

    // AES-256 (FIPS-197 C.3)
    issue(1'b1, PT, CT3, 1'b0);
    wait_out(1'b1);
    wait_idle(1'b1);

`ifdef AES_CTRL_ABORT_EN
    // Abort in ROUND
    issue(1'b0, PT, CT1, 1'b0);
    wait_ridx_a(4'd3);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    if (exp_a.size() > 0) exp_a.delete(exp_a.size() - 1);
    @(negedge clk);
    chk("abort_in_ready", 128'(ifa.in_ready), 128'(1));
    chk("abort_ridx",     128'(ridx_a),       128'(0));
    chk("abort_busy",     128'(busy_a),       128'(0));
    quiet_a("no_out_after_abort");
    issue(1'b0, PT, CT1, 1'b0);
    wait_out(1'b0);
    wait_idle(1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty_a",    128'(exp_a.size()), 128'(0));
    chk("sb_empty_b",    128'(exp_b.size()), 128'(0));
    chk("unexpected_a",  128'(unexp_a),      128'(0));
    chk("unexpected_b",  128'(unexp_b),      128'(0));
    chk("in_ready_inv_a", 128'(inv_a),       128'(0));
    chk("in_ready_inv_b", 128'(inv_b),       128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
